// File: rtl/image_spi_master.sv
// image_spi_master: streams one image frame (IMG_BYTES bytes, MSB first)
// to a digit-classifier accelerator over mode-0 SPI. It then clocks one
// more byte back and keeps the low nibble of that byte as the classified
// digit.
//
// Frame sequence:
//   IDLE -> SETUP -> (LOAD -> SHIFT) x IMG_BYTES -> READ -> HOLD -> FINISH
// Every pin-facing output comes straight from a flop. The next-state logic
// computes the next value of each output together with the next state, so
// the outputs always agree with the state they belong to.
module image_spi_master #(
  parameter int CLK_DIV   = 4,    // clk cycles per SCLK half-period, 2..255
  parameter int IMG_BYTES = 113   // bytes per frame, 1..1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       SCLK,
  output logic       COPI,
  output logic       CS,
  input  logic       CIPO,
  output logic       busy,
  output logic       done,
  output logic [3:0] result
);

  localparam int              BW        = $clog2(IMG_BYTES + 1);
  localparam logic [7:0]      DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0]   LAST_BYTE = BW'(IMG_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, LOAD, SHIFT, READ, HOLD, FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    div_q, div_d;        // half-period / wait-phase counter
  logic [2:0]    bit_q, bit_d;        // bit index within the current byte
  logic [BW-1:0] byte_q, byte_d;      // index of the byte being shifted
  logic [6:0]    tx_sr_q, tx_sr_d;    // bits still to send (bit 7 already on COPI)
  logic [3:0]    rx_sr_q, rx_sr_d;    // only the low nibble of the reply survives
  logic          sclk_q, sclk_d;
  logic          cs_q, cs_d;
  logic          copi_q, copi_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [3:0]    result_q, result_d;

  logic          div_last;

  assign div_last = (div_q == DIV_LAST);

  // Next-state and next-output logic for the frame sequencer.
  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    tx_sr_d  = tx_sr_q;
    rx_sr_d  = rx_sr_q;
    sclk_d   = sclk_q;
    cs_d     = cs_q;
    copi_d   = copi_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        cs_d   = 1'b1;
        copi_d = 1'b0;
        if (start) begin
          state_d = SETUP;
          cs_d    = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
        end
      end

      // CS low, SCLK low for CLK_DIV cycles before the first byte.
      SETUP: begin
        if (div_last) begin
          state_d = LOAD;
          div_d   = '0;
        end else begin
          div_d = div_q + 8'd1;
        end
      end

      // Wait for a byte. SCLK stays low, so a stalled source only stretches
      // the low phase and never produces an extra clock edge.
      LOAD: begin
        if (tx_valid && ready_q) begin
          state_d = SHIFT;
          tx_sr_d = tx_data[6:0];
          copi_d  = tx_data[7];
          bit_d   = '0;
          div_d   = '0;
        end
      end

      // SHIFT and READ share the SCLK generator. COPI only moves on the
      // falling edge; CIPO is captured on the rising edge.
      SHIFT, READ: begin
        if (!div_last) begin
          div_d = div_q + 8'd1;
        end else begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            if (state_q == READ) rx_sr_d = {rx_sr_q[2:0], CIPO};
          end else begin
            sclk_d = 1'b0;
            if (bit_q != 3'd7) begin
              bit_d = bit_q + 3'd1;
              if (state_q == SHIFT) begin
                copi_d  = tx_sr_q[6];
                tx_sr_d = {tx_sr_q[5:0], 1'b0};
              end
            end else begin
              bit_d = '0;
              if (state_q == READ) begin
                state_d = HOLD;
              end else if (byte_q < LAST_BYTE) begin
                byte_d  = byte_q + BW'(1);
                state_d = LOAD;
              end else begin
                state_d = READ;
                copi_d  = 1'b0;
              end
            end
          end
        end
      end

      // Keep CS low for CLK_DIV cycles after the last edge, then raise it
      // for one cycle before the frame is reported complete.
      HOLD: begin
        if (!cs_q) begin
          if (div_last) begin
            cs_d  = 1'b1;
            div_d = '0;
          end else begin
            div_d = div_q + 8'd1;
          end
        end else begin
          state_d = FINISH;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // These outputs depend only on the state being entered.
    ready_d = (state_d == LOAD);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FINISH);
    if (state_d == FINISH) result_d = rx_sr_q;
  end

  // State and output registers; reset forces an idle, deselected bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      tx_sr_q  <= '0;
      rx_sr_q  <= '0;
      sclk_q   <= 1'b0;
      cs_q     <= 1'b1;
      copi_q   <= 1'b0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the values
      // from before this edge no matter how the statements are ordered.
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      tx_sr_q  <= tx_sr_d;
      rx_sr_q  <= rx_sr_d;
      sclk_q   <= sclk_d;
      cs_q     <= cs_d;
      copi_q   <= copi_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign tx_ready = ready_q;
  assign SCLK     = sclk_q;
  assign CS       = cs_q;
  assign COPI     = copi_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;

endmodule

// File: tb/tb_image_spi_master.sv
// Directed testbench for image_spi_master. It uses three instances:
//   dut_a: CLK_DIV=2, IMG_BYTES=2 (bit stream, result, gap, start-while-busy)
//   dut_b: CLK_DIV=2, IMG_BYTES=4 (reset in the middle of a frame)
//   dut_c: default parameters     (start-to-done latency, CS setup time)
module tb_image_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;

  logic       start_a = 0, tx_valid_a = 0, cipo_a;
  logic [7:0] tx_data_a = 0;
  logic       tx_ready_a, sclk_a, copi_a, cs_a, busy_a, done_a;
  logic [3:0] result_a;

  logic       start_b = 0, tx_valid_b = 0, cipo_b;
  logic [7:0] tx_data_b = 0;
  logic       tx_ready_b, sclk_b, copi_b, cs_b, busy_b, done_b;
  logic [3:0] result_b;

  logic       start_c = 0, tx_valid_c = 0, cipo_c;
  logic [7:0] tx_data_c = 0;
  logic       tx_ready_c, sclk_c, copi_c, cs_c, busy_c, done_c;
  logic [3:0] result_c;

  image_spi_master #(.CLK_DIV(2), .IMG_BYTES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .tx_data(tx_data_a),
    .tx_valid(tx_valid_a), .tx_ready(tx_ready_a), .SCLK(sclk_a), .COPI(copi_a),
    .CS(cs_a), .CIPO(cipo_a), .busy(busy_a), .done(done_a), .result(result_a));

  image_spi_master #(.CLK_DIV(2), .IMG_BYTES(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .tx_ready(tx_ready_b), .SCLK(sclk_b), .COPI(copi_b),
    .CS(cs_b), .CIPO(cipo_b), .busy(busy_b), .done(done_b), .result(result_b));

  image_spi_master dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .tx_data(tx_data_c),
    .tx_valid(tx_valid_c), .tx_ready(tx_ready_c), .SCLK(sclk_c), .COPI(copi_c),
    .CS(cs_c), .CIPO(cipo_c), .busy(busy_c), .done(done_c), .result(result_c));

  assign cipo_b = 1'b0;
  assign cipo_c = 1'b0;

  int nvec  = 0;
  int nfail = 0;

  // Bus monitors: SCLK rising edges, COPI bits seen at those edges, and done pulses.
  int          edges_a = 0, edges_b = 0, base_a = 0, dones_a = 0, dones_b = 0;
  logic [63:0] bits_a  = '0;
  logic [7:0]  rsp_a   = '0;
  int          k_a;

  always @(posedge sclk_a) begin
    edges_a++;
    bits_a = {bits_a[62:0], copi_a};
  end
  always @(posedge sclk_b) edges_b++;
  always @(negedge cs_a) base_a = edges_a;
  always @(negedge clk) begin
    if (done_a) dones_a++;
    if (done_b) dones_b++;
  end

  // Accelerator model for dut_a: the reply byte goes out MSB first. The
  // first reply bit is driven after the 16th rising edge of the frame, i.e.
  // after the two image bytes, and the master samples it on the 17th edge.
  always @* begin
    k_a = edges_a - base_a;
    if (k_a >= 16 && k_a < 24) cipo_a = rsp_a[23 - k_a];
    else                       cipo_a = 1'b0;
  end

  // Sends one two-byte frame on dut_a with tx_valid held high, except for
  // an optional gap before byte 1. It can also pulse start during SHIFT.
  // lat is the number of clk edges from the one that samples start to the
  // one that raises done, or -1 if done never arrives.
  task automatic run_frame_a(input logic [7:0] b0, input logic [7:0] b1,
                             input int gap, input bit pulse,
                             output int lat, output int gap_seen,
                             output int gap_bad);
    int n, nacc, acc_n;
    bit acc, pulsed;
    lat = -1; gap_seen = 0; gap_bad = 0;
    n = 0; nacc = 0; acc_n = 0; pulsed = 0;
    @(negedge clk);
    start_a = 1; tx_valid_a = 1; tx_data_a = b0;
    @(posedge clk);
    #1 start_a = 0;
    while (lat < 0 && n < 3000) begin
      @(negedge clk);
      if (done_a) begin
        lat = n;
        break;
      end
      acc = tx_ready_a && tx_valid_a;
      if (gap > 0 && nacc == 1 && !tx_valid_a && tx_ready_a) begin
        gap_seen++;
        if (sclk_a !== 1'b0 || cs_a !== 1'b0) gap_bad++;
      end
      if (pulse && nacc == 1 && !pulsed && n == acc_n + 6) begin
        start_a = 1;
        pulsed  = 1;
      end
      @(posedge clk);
      n++;
      #1;
      start_a = 0;
      if (acc) begin
        nacc++;
        acc_n = n;
        if (nacc == 1) begin
          tx_data_a = b1;
          if (gap > 0) tx_valid_a = 0;
        end
      end
      if (gap > 0 && nacc == 1 && !tx_valid_a && gap_seen >= gap) tx_valid_a = 1;
    end
    tx_valid_a = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    nvec++; if (cs_a !== 1'b1)     begin nfail++; $display("FAIL reset_cs: got %b expected 1", cs_a); end
    nvec++; if (sclk_a !== 1'b0)   begin nfail++; $display("FAIL reset_sclk: got %b expected 0", sclk_a); end
    nvec++; if (copi_a !== 1'b0)   begin nfail++; $display("FAIL reset_copi: got %b expected 0", copi_a); end
    nvec++; if (tx_ready_a !== 1'b0) begin nfail++; $display("FAIL reset_tx_ready: got %b expected 0", tx_ready_a); end
    nvec++; if (busy_a !== 1'b0)   begin nfail++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    nvec++; if (done_a !== 1'b0)   begin nfail++; $display("FAIL reset_done: got %b expected 0", done_a); end
    nvec++; if (result_a !== 4'h0) begin nfail++; $display("FAIL reset_result: got %h expected 0", result_a); end
    nvec++; if ({cs_b, cs_c} !== 2'b11) begin nfail++; $display("FAIL reset_cs_bc: got %b expected 11", {cs_b, cs_c}); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    nvec++; if (busy_a !== 1'b0 || cs_a !== 1'b1) begin
      nfail++; $display("FAIL idle_after_reset: busy=%b cs=%b expected busy=0 cs=1", busy_a, cs_a);
    end
  endtask

  // 0xA5, 0x3C out, 0x07 back. The frame formula counts the start cycle and
  // the done cycle themselves, so the edge count between them is 105 - 2.
  task automatic test_basic_frame();
    int eb, db, lat, gs, gb;
    rsp_a = 8'h07; eb = edges_a; db = dones_a;
    run_frame_a(8'hA5, 8'h3C, 0, 1'b0, lat, gs, gb);
    repeat (5) @(negedge clk);
    nvec++; if (lat !== 103) begin nfail++; $display("FAIL basic_latency: got %0d edges expected 103", lat); end
    nvec++; if (edges_a - eb !== 24) begin nfail++; $display("FAIL basic_edges: got %0d expected 24", edges_a - eb); end
    nvec++; if (bits_a[23:0] !== 24'hA53C00) begin nfail++; $display("FAIL basic_stream: got %h expected a53c00", bits_a[23:0]); end
    nvec++; if (result_a !== 4'h7) begin nfail++; $display("FAIL basic_result: got %h expected 7", result_a); end
    nvec++; if (dones_a - db !== 1) begin nfail++; $display("FAIL basic_done_count: got %0d expected 1", dones_a - db); end
    nvec++; if (busy_a !== 1'b0 || cs_a !== 1'b1) begin
      nfail++; $display("FAIL basic_idle_after: busy=%b cs=%b expected busy=0 cs=1", busy_a, cs_a);
    end
  endtask

  task automatic test_upper_nibble();
    int eb, db, lat, gs, gb;
    rsp_a = 8'hF9; eb = edges_a; db = dones_a;
    run_frame_a(8'h81, 8'h7E, 0, 1'b0, lat, gs, gb);
    repeat (5) @(negedge clk);
    nvec++; if (result_a !== 4'h9) begin nfail++; $display("FAIL nibble_result: got %h expected 9", result_a); end
    nvec++; if (bits_a[23:0] !== 24'h817E00) begin nfail++; $display("FAIL nibble_stream: got %h expected 817e00", bits_a[23:0]); end
    nvec++; if (dones_a - db !== 1) begin nfail++; $display("FAIL nibble_done_count: got %0d expected 1", dones_a - db); end
  endtask

  task automatic test_tx_gap();
    int eb, db, lat, gs, gb;
    rsp_a = 8'h3B; eb = edges_a; db = dones_a;
    run_frame_a(8'hC3, 8'h18, 20, 1'b0, lat, gs, gb);
    repeat (5) @(negedge clk);
    nvec++; if (gs !== 20) begin nfail++; $display("FAIL gap_length: got %0d cycles expected 20", gs); end
    nvec++; if (gb !== 0) begin nfail++; $display("FAIL gap_bus_quiet: got %0d bad cycles expected 0", gb); end
    nvec++; if (edges_a - eb !== 24) begin nfail++; $display("FAIL gap_edges: got %0d expected 24", edges_a - eb); end
    nvec++; if (bits_a[23:0] !== 24'hC31800) begin nfail++; $display("FAIL gap_stream: got %h expected c31800", bits_a[23:0]); end
    nvec++; if (result_a !== 4'hB) begin nfail++; $display("FAIL gap_result: got %h expected b", result_a); end
    nvec++; if (dones_a - db !== 1) begin nfail++; $display("FAIL gap_done_count: got %0d expected 1", dones_a - db); end
  endtask

  task automatic test_start_during_shift();
    int eb, db, lat, gs, gb;
    rsp_a = 8'h42; eb = edges_a; db = dones_a;
    run_frame_a(8'hFF, 8'h01, 0, 1'b1, lat, gs, gb);
    repeat (60) @(negedge clk);
    nvec++; if (dones_a - db !== 1) begin nfail++; $display("FAIL busy_start_done_count: got %0d expected 1", dones_a - db); end
    nvec++; if (edges_a - eb !== 24) begin nfail++; $display("FAIL busy_start_edges: got %0d expected 24", edges_a - eb); end
    nvec++; if (result_a !== 4'h2) begin nfail++; $display("FAIL busy_start_result: got %h expected 2", result_a); end
    nvec++; if (busy_a !== 1'b0 || cs_a !== 1'b1) begin
      nfail++; $display("FAIL busy_start_idle: busy=%b cs=%b expected busy=0 cs=1", busy_a, cs_a);
    end
  endtask

  task automatic test_reset_abort();
    int eb, db, emid, eb2;
    bit got;
    eb = edges_b; db = dones_b;
    @(negedge clk);
    start_b = 1; tx_valid_b = 1; tx_data_b = 8'h5A;
    @(posedge clk);
    #1 start_b = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (edges_b - eb >= 12) break;
    end
    nvec++; if (edges_b - eb < 12) begin nfail++; $display("FAIL abort_reach_byte2: got %0d edges expected >= 12", edges_b - eb); end
    emid  = edges_b;
    rst_n = 1'b0;
    #1;
    nvec++; if (cs_b !== 1'b1) begin nfail++; $display("FAIL abort_cs_now: got %b expected 1", cs_b); end
    nvec++; if (sclk_b !== 1'b0 || busy_b !== 1'b0 || tx_ready_b !== 1'b0) begin
      nfail++; $display("FAIL abort_outputs: sclk=%b busy=%b tx_ready=%b expected 0 0 0", sclk_b, busy_b, tx_ready_b);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    nvec++; if (dones_b !== db) begin nfail++; $display("FAIL abort_no_done: got %0d pulses expected 0", dones_b - db); end
    nvec++; if (busy_b !== 1'b0 || cs_b !== 1'b1 || edges_b !== emid) begin
      nfail++; $display("FAIL abort_stays_idle: busy=%b cs=%b new_edges=%0d expected 0 1 0", busy_b, cs_b, edges_b - emid);
    end
    eb2 = edges_b; got = 0;
    @(negedge clk);
    start_b = 1;
    @(posedge clk);
    #1 start_b = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_b) begin got = 1; break; end
    end
    tx_valid_b = 0;
    repeat (5) @(negedge clk);
    nvec++; if (!got) begin nfail++; $display("FAIL abort_refrm_done: got timeout expected done"); end
    nvec++; if (edges_b - eb2 !== 40) begin nfail++; $display("FAIL abort_refrm_edges: got %0d expected 40", edges_b - eb2); end
    nvec++; if (dones_b - db !== 1) begin nfail++; $display("FAIL abort_refrm_done_count: got %0d expected 1", dones_b - db); end
  endtask

  // Defaults: 4*(2+16*114)+113+3 = 7420 cycles counting the start and done
  // cycles, which is 7418 clk edges between them.
  task automatic test_default_latency();
    int lat, cs_at, sclk_at;
    lat = -1; cs_at = -1; sclk_at = -1;
    @(negedge clk);
    start_c = 1; tx_valid_c = 1; tx_data_c = 8'h96;
    @(posedge clk);
    #1 start_c = 0;
    if (cs_c === 1'b0) cs_at = 0;
    for (int n = 1; n < 20000; n++) begin
      @(posedge clk);
      #1;
      if (cs_c === 1'b0 && cs_at < 0) cs_at = n;
      if (sclk_c === 1'b1 && sclk_at < 0) sclk_at = n;
      if (done_c === 1'b1) begin lat = n; break; end
    end
    tx_valid_c = 0;
    nvec++; if (lat !== 7418) begin nfail++; $display("FAIL default_latency: got %0d edges expected 7418", lat); end
    nvec++; if (cs_at !== 0) begin nfail++; $display("FAIL default_cs_fall: got edge %0d expected 0", cs_at); end
    nvec++; if (sclk_at < 0 || sclk_at - cs_at < 4) begin
      nfail++; $display("FAIL default_cs_to_sclk: got %0d cycles expected >= 4", sclk_at - cs_at);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_upper_nibble();
    test_tx_gap();
    test_start_during_shift();
    test_reset_abort();
    test_default_latency();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/image_spi_master.md
IMAGE_SPI_MASTER -- requirements
Module: image_spi_master

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per SCLK half-period; legal range 2..255.
REQ-002 Parameter IMG_BYTES, default 113, image bytes per frame (900 pixel bits, zero-padded); legal range 1..1023.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request one frame transfer; sampled only in IDLE.
REQ-006 tx_data  input  8  next image byte, MSB = first pixel.
REQ-007 tx_valid  input  1  tx_data valid.
REQ-008 tx_ready  output  1  byte accepted on cycle tx_valid & tx_ready.
REQ-009 SCLK  output  1  SPI clock to accelerator, mode 0 (idle low).
REQ-010 COPI  output  1  serial data to accelerator.
REQ-011 CS  output  1  chip select, active-low.
REQ-012 CIPO  input  1  serial data from accelerator.
REQ-013 busy  output  1  high from start acceptance until done pulse inclusive.
REQ-014 done  output  1  one-cycle pulse, frame complete.
REQ-015 result  output  4  last classified digit, held until next done.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, LOAD, SHIFT, READ, HOLD, FINISH.
REQ-017 IDLE: CS=1, SCLK=0, COPI=0, tx_ready=0; start=1 -> SETUP, busy=1 next cycle.
REQ-018 SETUP: CS=0, SCLK=0 for CLK_DIV cycles, then -> LOAD.
REQ-019 LOAD: tx_ready=1; on tx_valid&tx_ready capture byte, drive its MSB on COPI, -> SHIFT; no tx_valid -> stay, SCLK low, CS low.
REQ-020 SHIFT: 8 SCLK periods, each CLK_DIV cycles low then CLK_DIV cycles high; COPI changes only while SCLK low (at falling edge), MSB first.
REQ-021 After 8th bit: if byte counter < IMG_BYTES-1, increment -> LOAD; else -> READ.
REQ-022 READ: 8 further SCLK periods with COPI=0; CIPO sampled on each SCLK rising edge into rx shift register, MSB first.
REQ-023 HOLD: SCLK=0, CS=0 for CLK_DIV cycles, then CS=1 -> FINISH.
REQ-024 FINISH: result <= rx[3:0], done=1 one cycle, busy=0 next cycle, -> IDLE.
REQ-025 start while busy SHALL be ignored; start coincident with done SHALL be ignored.
REQ-026 Upper nibble of rx byte SHALL be discarded.
REQ-027 tx_ready SHALL be 1 only in LOAD; at most IMG_BYTES bytes accepted per frame.
REQ-028 Byte counter width ceil(log2(IMG_BYTES+1)); SHALL clear in SETUP, no wrap within a frame.
REQ-029 SCLK, CS, COPI SHALL be driven from flops (glitch-free).
REQ-030 Minimum frame length with tx_valid held 1: CLK_DIV*(2 + 16*(IMG_BYTES+1)) + IMG_BYTES + 3 cycles, start to done.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, CS=1, SCLK=0, COPI=0, tx_ready=0, busy=0, done=0, result=0, counters and shift registers 0.
REQ-032 Reset mid-frame SHALL abort without done; first post-reset frame starts only on new start.

Verification
REQ-033 CLK_DIV=2, IMG_BYTES=2, bytes 0xA5,0x3C, tx_valid held 1, slave returns 0x07 -> COPI bit stream 10100101 00111100 00000000, result=4'h7, one done pulse.
REQ-034 Slave returns 0xF9 -> result=4'h9 (upper nibble dropped).
REQ-035 tx_valid deasserted 20 cycles between bytes -> SCLK low and CS low throughout gap, no extra SCLK edges, 24 total rising edges.
REQ-036 start pulsed during SHIFT -> ignored, single frame, single done.
REQ-037 rst_n low during byte 2 of IMG_BYTES=4 -> CS=1 same cycle, no done; new start -> full 40-edge frame.
REQ-038 Default parameters, tx_valid held 1 -> start-to-done latency exactly per REQ-030, CS low-to-first-SCLK-rise >= 4 cycles.
